// File: rtl/game_phase_controller.sv
// game_phase_controller
// Moore FSM that sequences the title screen, the timed pre-round countdown,
// live play and the win/lose/draw end screens. IR commands, health values and
// attack activity drive the transitions; all timing is counted in video frames.
module game_phase_controller #(
  parameter int          FRAMES_PER_TICK = 60,
  parameter int          END_HOLD_FRAMES = 300,
  parameter logic [31:0] START_CODE_A    = 32'h20DF_5BA4,
  parameter logic [31:0] START_CODE_B    = 32'h20DF_5AA5,
  parameter logic [31:0] RESTART_CODE    = 32'h20DF_10EF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] ir_in,
  input  logic        ir_valid_in,
  input  logic        nf_in,
  input  logic        attack_valid_in,
  input  logic [2:0]  player_health_in,
  input  logic [2:0]  opponent_health_in,
  output logic [2:0]  phase_out,
  output logic        display_start_out,
  output logic        end_lose_out,
  output logic        end_win_out,
  output logic        game_active_out,
  output logic [1:0]  countdown_out,
  output logic        health_reset_out,
  output logic        ever_attack_out
);

  // A one-frame tick or hold period would give a zero-width counter.
  localparam int TICK_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam int HOLD_W = (END_HOLD_FRAMES > 1) ? $clog2(END_HOLD_FRAMES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAMES_PER_TICK - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD_FRAMES - 1);

  localparam logic [2:0] ST_START     = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_LOSE      = 3'd3;
  localparam logic [2:0] ST_WIN       = 3'd4;
  localparam logic [2:0] ST_DRAW      = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        digit_q, digit_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ever_q, ever_d;
  logic              hreset_q, hreset_d;

  logic cmd_start;
  logic cmd_restart;
  logic frame_adv;
  logic tick_last;
  logic hold_last;
  logic countdown_done;
  logic in_end_state;

  // Command decode; a recognised command in a cycle suppresses that cycle's frame count.
  always_comb begin
    cmd_start      = ir_valid_in && ((ir_in == START_CODE_A) || (ir_in == START_CODE_B));
    cmd_restart    = ir_valid_in && (ir_in == RESTART_CODE);
    frame_adv      = nf_in && !cmd_start && !cmd_restart;
    tick_last      = (tick_q == TICK_LAST);
    hold_last      = (hold_q == HOLD_LAST);
    countdown_done = frame_adv && tick_last && (digit_q == 2'd1);
    in_end_state   = (state_q == ST_LOSE) || (state_q == ST_WIN) || (state_q == ST_DRAW);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; restart always wins over health and frame events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: begin
        if (cmd_start) begin
          state_d = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (cmd_restart) begin
          state_d = ST_START;
        end else if (countdown_done) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (cmd_restart) begin
          state_d = ST_START;
        end else if (ever_q) begin
          // Health only counts once this round has seen an attack.
          if ((player_health_in == 3'd0) && (opponent_health_in == 3'd0)) begin
            state_d = ST_DRAW;
          end else if (player_health_in == 3'd0) begin
            state_d = ST_LOSE;
          end else if (opponent_health_in == 3'd0) begin
            state_d = ST_WIN;
          end
        end
      end
      ST_LOSE, ST_WIN, ST_DRAW: begin
        if (cmd_restart) begin
          state_d = ST_START;
        end else if (frame_adv && hold_last) begin
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // Counter, attack-latch and health-reset next values.
  always_comb begin
    tick_d   = tick_q;
    digit_d  = digit_q;
    hold_d   = hold_q;
    ever_d   = ever_q;
    hreset_d = 1'b0;
    if (state_q == ST_START) begin
      if (cmd_start) begin
        tick_d   = '0;
        digit_d  = 2'd3;
        ever_d   = 1'b0;
        hreset_d = 1'b1;
      end
    end else if (state_q == ST_COUNTDOWN) begin
      if (frame_adv) begin
        if (tick_last) begin
          tick_d  = '0;
          digit_d = digit_q - 2'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
    end else if (state_q == ST_PLAY) begin
      // Keeps the hold counter cleared so any end screen starts from zero.
      hold_d = '0;
      if (attack_valid_in) begin
        ever_d = 1'b1;
      end
    end else if (in_end_state) begin
      if (frame_adv) begin
        if (hold_last) begin
          hold_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end
  end

  // Counter, attack-latch and health-reset registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tick_q   <= '0;
      digit_q  <= 2'd3;
      hold_q   <= '0;
      ever_q   <= 1'b0;
      hreset_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      digit_q  <= digit_d;
      hold_q   <= hold_d;
      ever_q   <= ever_d;
      hreset_q <= hreset_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    phase_out         = state_q;
    display_start_out = (state_q == ST_START);
    end_lose_out      = (state_q == ST_LOSE);
    end_win_out       = (state_q == ST_WIN);
    game_active_out   = (state_q == ST_PLAY);
    countdown_out     = (state_q == ST_COUNTDOWN) ? digit_q : 2'd0;
    health_reset_out  = hreset_q;
    ever_attack_out   = ever_q;
  end

endmodule

// File: doc/game_phase_controller.md
# game_phase_controller

Sequences the game's display phases: title screen, pre-round countdown, live play, and win/lose/draw end screens. It decodes remote (IR) commands, health values and attack activity into the phase flags used by the display mux and by game logic. It replaces ad-hoc flag logic in the display path with one Moore FSM, and adds a timed countdown, end-screen timeout, restart/abort and a health-reset request. Counting is per video frame, driven by the frame strobe.

## Interface
Parameters:
- FRAMES_PER_TICK, 60: new-frame pulses per countdown step (1 s at 60 Hz).
- END_HOLD_FRAMES, 300: frames an end screen is held before returning to START.
- START_CODE_A, 32'h20DF_5BA4: IR code that starts a round.
- START_CODE_B, 32'h20DF_5AA5: alternate IR code that starts a round.
- RESTART_CODE, 32'h20DF_10EF: IR code that aborts or clears back to START.

Ports:
- clk_in  input  1  system/pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- ir_in  input  32  decoded IR command word.
- ir_valid_in  input  1  one-cycle strobe; ir_in is sampled only when this is high.
- nf_in  input  1  one-cycle new-frame pulse.
- attack_valid_in  input  1  an attack was registered this cycle.
- player_health_in  input  3  player health; 0 = dead.
- opponent_health_in  input  3  opponent health; 0 = dead.
- phase_out  output  3  current state encoding.
- display_start_out  output  1  title screen shown.
- end_lose_out  output  1  lose screen shown.
- end_win_out  output  1  win screen shown.
- game_active_out  output  1  gameplay enabled.
- countdown_out  output  2  countdown digit 3..1; 0 outside COUNTDOWN.
- health_reset_out  output  1  one-cycle request to restore both health values.
- ever_attack_out  output  1  at least one attack seen this round.

## Operation
- States and phase_out encoding: START=0, COUNTDOWN=1, PLAY=2, LOSE=3, WIN=4, DRAW=5. Codes 6 and 7 are unreachable; if entered, go to START next cycle.
- A command is accepted only when ir_valid_in=1 and ir_in matches exactly.
- START:
  - START_CODE_A or START_CODE_B → COUNTDOWN.
  - On that transition: load tick_cnt=0 and digit=3, clear ever_attack, pulse health_reset_out.
  - All other codes are ignored.
- COUNTDOWN:
  - Each nf_in increments tick_cnt.
  - When tick_cnt = FRAMES_PER_TICK-1 and nf_in=1: tick_cnt←0 and digit decrements.
  - When digit=1 decrements, go to PLAY instead (digit 0 is never shown).
  - RESTART_CODE → START.
- PLAY:
  - attack_valid_in=1 sets ever_attack; it stays set until the next round start.
  - Health is evaluated only when ever_attack=1, using the registered value (not the same-cycle attack).
  - Priority: both healths 0 → DRAW; else player 0 → LOSE; else opponent 0 → WIN.
  - RESTART_CODE → START and has priority over health evaluation.
- LOSE / WIN / DRAW:
  - On entry, hold_cnt←0; each nf_in increments it.
  - When hold_cnt = END_HOLD_FRAMES-1 and nf_in=1 → START.
  - RESTART_CODE → START immediately; start codes are ignored.
- Simultaneous events: a valid IR command takes priority over nf_in in the same cycle; the counter does not advance that cycle.
- Output decode from state:
  - display_start_out = (START).
  - end_lose_out = (LOSE), end_win_out = (WIN); both are 0 in DRAW.
  - game_active_out = (PLAY).
  - countdown_out = digit in COUNTDOWN, else 0.
- Counter widths: tick_cnt is $clog2(FRAMES_PER_TICK) bits; hold_cnt is $clog2(END_HOLD_FRAMES) bits. Neither wraps; each is reloaded on state entry.

## Timing
- Reset:
  - state=START, display_start_out=1.
  - end_lose_out, end_win_out, game_active_out, health_reset_out, ever_attack_out = 0.
  - countdown_out=0, tick_cnt=0, hold_cnt=0.
  - Reset asserted mid-round discards all counts; no health_reset_out pulse is issued.
- State and all outputs are registered, or are decodes of registered state only. A qualifying input at edge N gives new outputs visible after edge N.
- health_reset_out is high for exactly the one cycle following the START→COUNTDOWN edge.
- Countdown duration from the accepting edge to PLAY is exactly 3·FRAMES_PER_TICK nf_in pulses.
- ever_attack_out goes high the cycle after the first attack_valid_in in PLAY.
- The earliest end-state entry is the cycle after that.
- attack_valid_in outside PLAY is ignored.

## Test plan
- Reset, then ir_valid_in with 32'h20DF_5BA4 → phase_out=1, health_reset_out high for 1 cycle, countdown_out=3. Then 60 nf pulses → 2; 120 → 1; 180 → phase_out=2, game_active_out=1.
- PLAY with opponent_health_in=0 but no attack yet → remains PLAY. Pulse attack_valid_in → ever_attack_out=1 next cycle, then phase_out=4 and end_win_out=1.
- PLAY, attack seen, both healths 0 in the same cycle → phase_out=5, end_win_out=0, end_lose_out=0. After 300 nf pulses → phase_out=0, display_start_out=1.
- In LOSE, send RESTART_CODE together with an nf_in pulse → START on the next cycle and hold_cnt does not increment. A start code sent while in LOSE → no change.
- Set FRAMES_PER_TICK=2, assert rst_in mid-COUNTDOWN → all outputs at reset values. A subsequent start code restarts the countdown from 3.
- In START, send an unrecognised IR code, and separately a start code with ir_valid_in=0 → phase_out stays 0.
